mem16x32_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16x32 single-port memory (registered read, 1-cycle latency, write-over-read priority) between NUM_REQ requesters. Each requester issues one read or write per grant. The arbiter drives the memory's en/re/addr/data_in, waits for valid_out on reads, and routes the read data back to the owning requester. It sits between client blocks and the memory instance.

---
 rtl/mem16x32_rr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem16x32_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem16x32_rr_arbiter.sv
// Round-robin arbiter sharing one 16x32 registered-read memory between NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to bound RD_WAIT and answer a stuck read with err=1.
module mem16x32_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [4*NUM_REQ-1:0]  addr,
  input  logic [32*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [31:0]           rdata,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_re,
  output logic [3:0]            mem_addr,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out,
  input  logic                  mem_valid_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mem16x32_rr_arbiter: NUM_REQ must be 2..4 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_re_q, mem_re_d;
  logic [3:0]         mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_in_q, mem_data_in_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  logic               err_q, err_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic [7:0]         tmo_inc;
`endif

  logic               arb_any;
  logic [PW-1:0]      win_idx;
  logic               win_we;
  logic [3:0]         win_addr;
  logic [31:0]        win_wdata;
  int                 arb_dist;
  int                 arb_best;

  assign arb_any = |req;

  // Winner is the set request at the smallest distance past rr_ptr, wrapping around.
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    arb_dist  = 0;
    arb_best  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_dist = (i + NUM_REQ - 1 - int'(rr_ptr_q)) % NUM_REQ;
      if (req[i] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        win_idx   = PW'(i);
        win_we    = we[i];
        win_addr  = addr[4*i +: 4];
        win_wdata = wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    mem_en_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d         = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    tmo_inc       = tmo_cnt_q + 8'd1;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          rr_ptr_d          = win_idx;
          owner_d           = win_idx;
          gnt_d[win_idx]    = 1'b1;
          mem_addr_d        = win_addr;
          if (win_we) begin
            mem_data_in_d   = win_wdata;
            mem_en_d        = 1'b1;
            state_d         = WR;
          end else begin
            mem_re_d        = 1'b1;
            state_d         = RD;
          end
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        state_d = RD_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      RD_WAIT: begin
        if (mem_valid_out) begin
          rdata_d           = mem_data_out;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_inc == TMO_LIMIT) begin
          rdata_d           = '0;
          rvalid_d[owner_q] = 1'b1;
          err_d             = 1'b1;
          state_d           = IDLE;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rr_ptr_q      <= LAST_REQ;
      owner_q       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q         <= 1'b0;
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      mem_en_q      <= mem_en_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q         <= err_d;
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem16x32_rr_arbiter.sv
// Bench for mem16x32_rr_arbiter: behavioural memory, transaction-level reference model,
// directed scenarios plus randomized request mixes.
module tb_mem16x32_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [4*NUM_REQ-1:0]  addr;
  logic [32*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [31:0]           rdata;
  logic [NUM_REQ-1:0]    rvalid;
  logic                  err;
  logic                  mem_en;
  logic                  mem_re;
  logic [3:0]            mem_addr;
  logic [31:0]           mem_data_in;
  logic [31:0]           mem_data_out = '0;
  logic                  mem_valid_out = 1'b0;

  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];
  logic        pend_rd = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  int          mem_extra = 0;
  logic        mem_stall = 1'b0;
  int          force_extra = -1;

  bit          pend_req   [NUM_REQ];
  bit          pend_we    [NUM_REQ];
  logic [3:0]  pend_addr  [NUM_REQ];
  logic [31:0] pend_wdata [NUM_REQ];
  int          model_rr;
  int          testCount = 0;
  int          failCount = 0;
  int          win;

  mem16x32_rr_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .err(err),
    .mem_en(mem_en), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
  );

  always #5 clk = ~clk;

  // Memory model: write wins over read; read data appears one edge after re plus mem_extra.
  always @(posedge clk) begin
    mem_valid_out <= 1'b0;
    if (mem_en) begin
      mem_arr[mem_addr] <= mem_data_in;
    end else if (mem_re && !mem_stall) begin
      if (mem_extra == 0) begin
        mem_data_out  <= mem_arr[mem_addr];
        mem_valid_out <= 1'b1;
      end else begin
        pend_rd   <= 1'b1;
        pend_cnt  <= mem_extra;
        pend_data <= mem_arr[mem_addr];
      end
    end else if (pend_rd) begin
      if (pend_cnt <= 1) begin
        mem_data_out  <= pend_data;
        mem_valid_out <= 1'b1;
        pend_rd       <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]            = pend_req[i];
      we[i]             = pend_we[i];
      addr[4*i +: 4]    = pend_addr[i];
      wdata[32*i +: 32] = pend_wdata[i];
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
    checkOutput("en_re_exclusive", 32'(mem_en & mem_re), 32'd0);
  endtask

  task automatic setReq(input int r, input bit w, input logic [3:0] a, input logic [31:0] d);
    pend_req[r]   = 1'b1;
    pend_we[r]    = w;
    pend_addr[r]  = a;
    pend_wdata[r] = d;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NUM_REQ; i++) pend_req[i] = 1'b0;
    applyStimulus();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    checkOutput({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_data_in"}, mem_data_in, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearReqs();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    model_rr = NUM_REQ - 1;
  endtask

  // One arbitration slot: predict the winner by round-robin distance, then check the access end to end.
  task automatic runArbitration(output int winner);
    int          w;
    int          wait_steps;
    logic [3:0]  a;
    logic [31:0] exp_data;
    logic        exp_err;
    applyStimulus();
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (model_rr + k) % NUM_REQ;
      if (w < 0 && pend_req[idx]) w = idx;
    end
    winner = w;
    stepClock();
    checkOutput("rvalid_outside_wait", 32'(rvalid), 32'd0);
    if (w < 0) begin
      checkOutput("gnt_no_req", 32'(gnt), 32'd0);
      checkOutput("mem_en_no_req", 32'(mem_en), 32'd0);
      checkOutput("mem_re_no_req", 32'(mem_re), 32'd0);
      return;
    end
    a = pend_addr[w];
    checkOutput("gnt_winner", 32'(gnt), 32'(1 << w));
    checkOutput("mem_addr", 32'(mem_addr), 32'(a));
    model_rr = w;
    pend_req[w] = 1'b0;
    applyStimulus();
    if (pend_we[w]) begin
      checkOutput("mem_en_write", 32'(mem_en), 32'd1);
      checkOutput("mem_data_in", mem_data_in, pend_wdata[w]);
      ref_mem[a] = pend_wdata[w];
      stepClock();
      checkOutput("gnt_drop_wr", 32'(gnt), 32'd0);
      checkOutput("mem_en_drop", 32'(mem_en), 32'd0);
    end else begin
      checkOutput("mem_re_read", 32'(mem_re), 32'd1);
      mem_extra = (force_extra >= 0) ? force_extra : int'($urandom_range(0, 2));
      if (mem_stall) begin
        wait_steps = TIMEOUT;
        exp_data   = 32'd0;
        exp_err    = 1'b1;
      end else begin
        wait_steps = mem_extra + 1;
        exp_data   = ref_mem[a];
        exp_err    = 1'b0;
      end
      stepClock();
      checkOutput("gnt_drop_rd", 32'(gnt), 32'd0);
      checkOutput("mem_re_drop", 32'(mem_re), 32'd0);
      checkOutput("rvalid_early_rd", 32'(rvalid), 32'd0);
      for (int k = 1; k <= wait_steps; k++) begin
        stepClock();
        if (k < wait_steps) begin
          checkOutput("rvalid_early", 32'(rvalid), 32'd0);
        end else begin
          checkOutput("rvalid_owner", 32'(rvalid), 32'(1 << w));
          checkOutput("rdata", rdata, exp_data);
          checkOutput("err", 32'(err), 32'(exp_err));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 32'hA5C3_0000 | 32'(i * 17 + 1);
      ref_mem[i] = 32'hA5C3_0000 | 32'(i * 17 + 1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_req[i] = 1'b0; pend_we[i] = 1'b0; pend_addr[i] = '0; pend_wdata[i] = '0;
    end
    doReset();

    // Directed write then read-back of the same word through another requester.
    setReq(0, 1'b1, 4'd3, 32'hDEADBEEF);
    runArbitration(win);
    checkOutput("first_write_winner", 32'(win), 32'd0);
    force_extra = 0;
    setReq(1, 1'b0, 4'd3, 32'd0);
    runArbitration(win);
    checkOutput("readback_winner", 32'(win), 32'd1);
    checkOutput("readback_data", rdata, 32'hDEADBEEF);
    force_extra = -1;

    // Two readers held continuously must alternate.
    doReset();
    setReq(0, 1'b0, 4'd5, 32'd0);
    setReq(1, 1'b0, 4'd3, 32'd0);
    for (int n = 0; n < 4; n++) begin
      runArbitration(win);
      checkOutput("fair_order", 32'(win), 32'(exp_order[n]));
      setReq(win, 1'b0, pend_addr[win], 32'd0);
    end
    clearReqs();

    // Reset during RD_WAIT: everything clears at once and the late response is dropped.
    setReq(1, 1'b0, 4'd7, 32'd0);
    applyStimulus();
    stepClock();
    checkOutput("midrst_gnt", 32'(gnt), 32'd2);
    clearReqs();
    mem_extra = 3;
    stepClock();
    stepClock();
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    #2;
    rst = 1'b0;
    model_rr = NUM_REQ - 1;
    for (int n = 0; n < 4; n++) begin
      stepClock();
      checkOutput("late_valid_rvalid", 32'(rvalid), 32'd0);
      checkOutput("late_valid_gnt", 32'(gnt), 32'd0);
    end
    setReq(0, 1'b0, 4'd1, 32'd0);
    setReq(1, 1'b0, 4'd2, 32'd0);
    runArbitration(win);
    checkOutput("post_reset_winner", 32'(win), 32'd0);
    clearReqs();

    // Upper requesters only, starting from the reset pointer.
    doReset();
    setReq(2, 1'b0, 4'd3, 32'd0);
    setReq(3, 1'b1, 4'd9, 32'h1234_5678);
    runArbitration(win);
    checkOutput("upper_first", 32'(win), 32'd2);
    runArbitration(win);
    checkOutput("upper_second", 32'(win), 32'd3);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_stall = 1'b1;
    setReq(1, 1'b0, 4'd4, 32'd0);
    runArbitration(win);
    mem_stall = 1'b0;
    setReq(0, 1'b1, 4'd4, 32'hCAFE_F00D);
    runArbitration(win);
    checkOutput("after_timeout_winner", 32'(win), 32'd0);
`endif

    // Randomized mix of reads, writes and idle slots.
    for (int n = 0; n < 120; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_req[i] && $urandom_range(0, 2) == 0)
          setReq(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
      runArbitration(win);
    end
    clearReqs();
    stepClock();
    checkOutput("final_rvalid_idle", 32'(rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
